imem_fetch_responder: RTL and testbench
=======================================

Name: imem_fetch_responder

Overview:
- Instruction-memory responder for the program counter's fetch requests in the single-cycle RISC-V core.
- Accepts a word address over a valid/ready request channel and returns the 32-bit instruction after a configurable number of wait states over a valid/ready response channel.
- Raises the sticky finish_flag that freezes the PC once a halt instruction or a fetch error is reached.
- Includes a write-only load port for preloading the program image.

Parameters:
DEPTH, 256, number of 32-bit instruction words; power of two, minimum 4.
WAIT_STATES, 1, extra cycles between request acceptance and response; range 0..15.
HALT_INSTR, 32'h00000073, instruction encoding (ecall) that ends the program.

Ports:
clk  input  1  clock; all state updates on its rising edge.
reset  input  1  asynchronous reset, active-low; asserted when 0.
req_valid  input  1  fetch request present.
req_addr  input  32  byte address of the instruction (PC value).
req_ready  output  1  responder can accept a request.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts the response.
rsp_instr  output  32  fetched instruction; 32'h00000013 (nop) on error.
rsp_error  output  1  request was misaligned or out of range.
finish_flag  output  1  sticky program-end indication to the PC.
load_en  input  1  write load_data into memory this cycle.
load_addr  input  $clog2(DEPTH)  word index for the load write.
load_data  input  32  word to write.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, wait counter=0, rsp_valid=0, rsp_instr=0, rsp_error=0, finish_flag=0. Any pending request is dropped. Memory array is not reset and keeps its contents.
- States:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0, counter running.
  - RESP: req_ready=0, rsp_valid=1.
  - HALT: req_ready=0, rsp_valid=0, finish_flag=1.
- Acceptance: occurs at a rising edge where req_valid && req_ready. req_addr is captured into an internal register at that edge; later changes to req_addr are ignored.
- Error check at acceptance: req_addr[1:0]!=0, or req_addr >= DEPTH*4. Example: 32'hFFFFFFFC is out of range.
  - Error: go to RESP with rsp_error=1 and rsp_instr=32'h00000013. No wait states apply.
  - No error, WAIT_STATES==0: read mem[req_addr>>2] and go to RESP.
  - No error, WAIT_STATES>0: load counter=WAIT_STATES and go to WAIT.
- WAIT: counter decrements each cycle. On the cycle the counter is 1, read memory at the captured address and go to RESP.
- Latency: with acceptance at edge T, rsp_valid first rises after edge T+1+WAIT_STATES for a good address, and after edge T+1 for an error.
- RESP: rsp_valid, rsp_instr and rsp_error are held stable until rsp_valid && rsp_ready. At that handshake edge:
  - If rsp_error==1 or rsp_instr==HALT_INSTR: go to HALT; finish_flag=1 from that edge.
  - Otherwise: go to IDLE with rsp_valid=0.
  - A new request cannot be accepted in the same cycle as the response handshake. Minimum spacing between acceptances is 2+WAIT_STATES cycles.
- HALT: terminal state. All requests are ignored. finish_flag stays 1 until reset.
- Load port: load_en writes mem[load_addr] at the rising edge, in any state.
  - If a load and a fetch read hit the same word on the same edge, the read returns the old data.
  - Loads do not affect the FSM.
- rsp_instr and rsp_error keep their last values when rsp_valid=0. Bench checks them only while rsp_valid=1.
- Reset asserted in WAIT or RESP: returns to IDLE immediately. No response is produced for the aborted request.

Test Plan:
- Load mem[0..2]=32'h00500093, 32'h00108113, 32'h00000073; WAIT_STATES=1; request addr 0 with rsp_ready=1 -> rsp_valid rises 2 cycles after acceptance, rsp_instr=32'h00500093, rsp_error=0, finish_flag=0.
- Fetch addr 4 then addr 8 -> second response rsp_instr=32'h00000073; finish_flag=1 at the response handshake edge; further req_valid gives req_ready=0 and no rsp_valid.
- Request addr 32'hFFFFFFFC, then, after reset, addr 32'h00000006 -> each returns rsp_error=1, rsp_instr=32'h00000013 one cycle after acceptance, then finish_flag=1.
- Hold rsp_ready=0 for 5 cycles during RESP with addr 4 -> rsp_valid and rsp_instr=32'h00108113 stable all 5 cycles; req_ready=0 throughout; IDLE on the cycle after rsp_ready=1.
- Drive reset low while in WAIT (WAIT_STATES=3) -> rsp_valid=0 and finish_flag=0 immediately; after release, fetch addr 0 returns 32'h00500093, showing memory retained.
- Same edge: load_en to word 1 with 32'hDEADBEEF and a fetch read of word 1 (WAIT_STATES=0) -> response 32'h00108113; next fetch of addr 4 returns 32'hDEADBEEF.

Source files
------------

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: instruction memory answering PC fetches over
// valid/ready, with WAIT_STATES latency, a sticky halt flag and a load port.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_addr      : fetch request (byte address)
//   rsp_valid/rsp_ready/rsp_instr     : fetch response
//   rsp_error                         : misaligned or out-of-range request
//   finish_flag                       : sticky end-of-program to the PC
//   load_en/load_addr/load_data       : word write port for the image
module imem_fetch_responder #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] HALT_INSTR  = 32'h00000073
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  output logic                     req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_instr,
  output logic                     rsp_error,
  output logic                     finish_flag,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);

  localparam int          AW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [3:0]  WS  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    HALT
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [3:0]    cnt_q;
  logic [3:0]    cnt_d;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] idx_d;
  logic [31:0]   instr_q;
  logic [31:0]   instr_d;
  logic          err_q;
  logic          err_d;

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] req_idx;
  logic          bad_addr;

  assign req_idx  = req_addr[AW+1:2];
  // Any address bit above the array span means out of range.
  assign bad_addr = (req_addr[1:0] != 2'b00)
                  || (req_addr[31:AW+2] != '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    instr_d     = instr_q;
    err_d       = err_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    finish_flag = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          idx_d = req_idx;
          if (bad_addr) begin
            state_d = RESP;
            instr_d = NOP;
            err_d   = 1'b1;
          end else if (WS == 4'd0) begin
            state_d = RESP;
            instr_d = mem[req_idx];
            err_d   = 1'b0;
          end else begin
            state_d = WAIT;
            cnt_d   = WS;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          instr_d = mem[idx_q];
          err_d   = 1'b0;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          if (err_q || (instr_q == HALT_INSTR)) begin
            state_d = HALT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HALT: begin
        finish_flag = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  // Array is never reset; a read on the write edge sees the old word.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  assign rsp_instr = instr_q;
  assign rsp_error = err_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder: three responders (WAIT_STATES 1, 3, 0) sharing
// one load port, checked against a transaction-level memory model.
module tb_imem_fetch_responder;

  localparam int          DEPTH = 64;
  localparam int          AW    = 6;
  localparam int          N     = 3;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] HALT  = 32'h00000073;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid   [N];
  logic [31:0]   req_addr    [N];
  logic          req_ready   [N];
  logic          rsp_valid   [N];
  logic          rsp_ready   [N];
  logic [31:0]   rsp_instr   [N];
  logic          rsp_error   [N];
  logic          finish_flag [N];
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;

  logic [31:0]   ref_mem [DEPTH];
  bit            halted  [N];
  int            n_chk = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    imem_fetch_responder #(
      .DEPTH      (DEPTH),
      .WAIT_STATES((g == 0) ? 1 : (g == 1) ? 3 : 0),
      .HALT_INSTR (HALT)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_addr   (req_addr[g]),
      .req_ready  (req_ready[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_instr  (rsp_instr[g]),
      .rsp_error  (rsp_error[g]),
      .finish_flag(finish_flag[g]),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_data  (load_data)
    );
  end

  function automatic int ws_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 0;
  endfunction

  function automatic string tag(input string s, input int i);
    return $sformatf("%s[%0d]", s, i);
  endfunction

  task automatic chk(input string t, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;
      rsp_ready[i] = 1'b0;
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk(tag("rst_valid", i), 32'(rsp_valid[i]), 0);
      chk(tag("rst_ready", i), 32'(req_ready[i]), 1);
      chk(tag("rst_flag", i), 32'(finish_flag[i]), 0);
      chk(tag("rst_instr", i), rsp_instr[i], 0);
      chk(tag("rst_error", i), 32'(rsp_error[i]), 0);
      halted[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = d;
    @(posedge clk);
    #1;
    load_en   = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic fetch(input int i, input logic [31:0] a, input int hold,
                       input bit ld, input int la, input logic [31:0] ld_d);
    bit          err;
    bit          hlt;
    int          lat;
    int          w;
    logic [31:0] exp;
    err = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
    lat = err ? 0 : ws_of(i);
    w   = int'(a[AW+1:2]);
    if (halted[i]) begin
      req_valid[i] = 1'b1;
      req_addr[i]  = a;
      repeat (3) begin
        @(posedge clk);
        #1;
        chk(tag("halt_ready", i), 32'(req_ready[i]), 0);
        chk(tag("halt_valid", i), 32'(rsp_valid[i]), 0);
        chk(tag("halt_flag", i), 32'(finish_flag[i]), 1);
      end
      req_valid[i] = 1'b0;
      return;
    end
    chk(tag("idle_ready", i), 32'(req_ready[i]), 1);
    req_valid[i] = 1'b1;
    req_addr[i]  = a;
    if (ld) begin
      load_en   = 1'b1;
      load_addr = AW'(la);
      load_data = ld_d;
    end
    // A zero-latency read shares the edge with the load and sees old data.
    if (err) exp = NOP;
    else if (ld && la == w && lat != 0) exp = ld_d;
    else exp = ref_mem[w];
    hlt = err || (exp == HALT);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    req_addr[i]  = $urandom;
    load_en      = 1'b0;
    if (ld) ref_mem[la] = ld_d;
    for (int k = 0; k < lat; k++) begin
      chk(tag("wait_valid", i), 32'(rsp_valid[i]), 0);
      chk(tag("wait_ready", i), 32'(req_ready[i]), 0);
      @(posedge clk);
      #1;
    end
    for (int k = 0; k <= hold; k++) begin
      chk(tag("rsp_valid", i), 32'(rsp_valid[i]), 1);
      chk(tag("rsp_instr", i), rsp_instr[i], exp);
      chk(tag("rsp_error", i), 32'(rsp_error[i]), 32'(err));
      chk(tag("rsp_ready", i), 32'(req_ready[i]), 0);
      chk(tag("rsp_flag", i), 32'(finish_flag[i]), 0);
      if (k == hold) rsp_ready[i] = 1'b1;
      @(posedge clk);
      #1;
    end
    rsp_ready[i] = 1'b0;
    chk(tag("done_valid", i), 32'(rsp_valid[i]), 0);
    chk(tag("done_flag", i), 32'(finish_flag[i]), 32'(hlt));
    chk(tag("done_ready", i), 32'(req_ready[i]), 32'(!hlt));
    halted[i] = hlt;
  endtask

  task automatic abort_in_wait(input int i, input logic [31:0] a);
    req_valid[i] = 1'b1;
    req_addr[i]  = a;
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    @(posedge clk);
    #1;
    chk(tag("abort_ready", i), 32'(req_ready[i]), 0);
    chk(tag("abort_valid", i), 32'(rsp_valid[i]), 0);
    do_reset();
  endtask

  initial begin
    int          i;
    int          r;
    logic [31:0] a;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b0;
      req_addr[k]  = '0;
      rsp_ready[k] = 1'b0;
    end
    do_reset();
    load(0, 32'h00500093);
    load(1, 32'h00108113);
    load(2, 32'h00000073);
    for (int k = 3; k < DEPTH; k++) load(k, $urandom);

    fetch(0, 32'h0, 0, 1'b0, 0, 0);
    fetch(0, 32'h4, 5, 1'b0, 0, 0);
    fetch(0, 32'h8, 0, 1'b0, 0, 0);
    fetch(0, 32'hC, 0, 1'b0, 0, 0);

    fetch(1, 32'hFFFFFFFC, 0, 1'b0, 0, 0);
    do_reset();
    fetch(1, 32'h00000006, 1, 1'b0, 0, 0);
    do_reset();
    fetch(1, 32'(DEPTH * 4 - 4), 0, 1'b0, 0, 0);
    fetch(1, 32'(DEPTH * 4), 0, 1'b0, 0, 0);
    do_reset();

    abort_in_wait(1, 32'h0);
    fetch(1, 32'h0, 0, 1'b0, 0, 0);

    fetch(2, 32'h4, 0, 1'b1, 1, 32'hDEADBEEF);
    fetch(2, 32'h4, 0, 1'b0, 0, 0);

    for (int t = 0; t < 80; t++) begin
      i = $urandom_range(0, N - 1);
      r = $urandom_range(0, 9);
      if (halted[i] && $urandom_range(0, 1) == 1) do_reset();
      if (r < 7) a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (r < 9) a = ($urandom & 32'h0000_00FC) | 32'($urandom_range(1, 3));
      else a = ($urandom | 32'h0000_0100) & 32'hFFFF_FFFC;
      fetch(i, a, $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
            $urandom_range(0, DEPTH - 1), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
